instr_cache: RTL and testbench

// - Parametrised direct-mapped instruction cache; replaces the fixed always-hit instruction ROM between PC and decode.
// - Core reads combinationally; hit_o=0 means stall. Misses refill a full line from backing memory via req/ready + valid beats.
// - hit_o becomes a real ready signal; flush_i provides invalidation (e.g. after self-modifying code or program load).

---
 rtl/instr_cache_pkg.sv | 14 +
 rtl/icache_line_ram.sv | 21 ++
 rtl/instr_cache.sv | 97 +++++++++
 tb/tb_instr_cache.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/instr_cache_pkg.sv
// instr_cache_pkg: shared types and geometry helpers for the instruction cache
package instr_cache_pkg;
   typedef enum logic [1:0] {IDLE, REQ, REFILL} state_t;
   localparam int WORD_W = 32;
   function automatic int off_w(input int line_words);
      return $clog2(line_words) + 2;
   endfunction
   function automatic int idx_w(input int num_lines);
      return $clog2(num_lines);
   endfunction
   function automatic int tag_w(input int addr_w, input int line_words, input int num_lines);
      return addr_w - idx_w(num_lines) - off_w(line_words);
   endfunction
endpackage

// File: rtl/icache_line_ram.sv
// icache_line_ram: line data store with async read and sync write
module icache_line_ram
   import instr_cache_pkg::*;
#(
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic                             clk_i,
   input  logic [idx_w(NUM_LINES)-1:0]      rd_idx,
   input  logic [off_w(LINE_WORDS)-3:0]     rd_word,
   output logic [WORD_W-1:0]                rd_data,
   input  logic                             we,
   input  logic [idx_w(NUM_LINES)-1:0]      wr_idx,
   input  logic [off_w(LINE_WORDS)-3:0]     wr_word,
   input  logic [WORD_W-1:0]                wr_data
);
   logic [WORD_W-1:0] mem [NUM_LINES][LINE_WORDS];
   assign rd_data = mem[rd_idx][rd_word];
   always_ff @(posedge clk_i)
      if (we) mem[wr_idx][wr_word] <= wr_data;
endmodule

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped instruction cache with line refill and flush
module instr_cache
   import instr_cache_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4,
   parameter int NUM_LINES  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] PC_addr_i,
   output logic [WORD_W-1:0] instr_o,
   output logic              hit_o,
   input  logic              flush_i,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ready_i,
   input  logic              mem_valid_i,
   input  logic [WORD_W-1:0] mem_data_i
);
   localparam int OFF_W = off_w(LINE_WORDS);
   localparam int IDX_W = idx_w(NUM_LINES);
   localparam int TAG_W = tag_w(ADDR_W, LINE_WORDS, NUM_LINES);
   localparam int WRD_W = OFF_W - 2;
   localparam logic [WRD_W-1:0] LAST = WRD_W'(LINE_WORDS - 1);
   state_t               state;
   logic [NUM_LINES-1:0] valid;
   logic [TAG_W-1:0]     tags [NUM_LINES];
   logic [WRD_W-1:0]     cnt;
   logic                 discard;
   logic [WORD_W-1:0]    rd_data;
   logic [IDX_W-1:0]     pc_idx, fill_idx;
   logic [WRD_W-1:0]     pc_word;
   logic [TAG_W-1:0]     pc_tag, fill_tag;
   logic                 beat, last, unused_bits;
   assign pc_idx      = PC_addr_i[OFF_W +: IDX_W];
   assign pc_word     = PC_addr_i[2 +: WRD_W];
   assign pc_tag      = PC_addr_i[ADDR_W-1 -: TAG_W];
   assign fill_idx    = mem_addr_o[OFF_W +: IDX_W];
   assign fill_tag    = mem_addr_o[ADDR_W-1 -: TAG_W];
   assign unused_bits = ^PC_addr_i[1:0];
   assign hit_o       = valid[pc_idx] && tags[pc_idx] == pc_tag;
   assign instr_o     = hit_o ? rd_data : '0;
   assign beat        = state == REFILL && mem_valid_i;
   assign last        = beat && cnt == LAST;
   icache_line_ram #(.LINE_WORDS(LINE_WORDS), .NUM_LINES(NUM_LINES)) u_ram (
      .clk_i   (clk_i),
      .rd_idx  (pc_idx),
      .rd_word (pc_word),
      .rd_data (rd_data),
      .we      (beat),
      .wr_idx  (fill_idx),
      .wr_word (cnt),
      .wr_data (mem_data_i)
   );
   always_ff @(posedge clk_i)
      if (last) tags[fill_idx] <= fill_tag;
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= IDLE;
         cnt        <= '0;
         discard    <= 1'b0;
         mem_req_o  <= 1'b0;
         mem_addr_o <= '0;
         valid      <= '0;
      end else begin
         case (state)
            IDLE:
               if (!hit_o && !flush_i) begin
                  state      <= REQ;
                  mem_req_o  <= 1'b1;
                  mem_addr_o <= {PC_addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
               end
            REQ:
               if (mem_ready_i) begin
                  state     <= REFILL;
                  mem_req_o <= 1'b0;
                  cnt       <= '0;
               end
            REFILL:
               if (mem_valid_i) begin
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST) begin
                     state   <= IDLE;
                     discard <= 1'b0;
                  end
               end
            default: state <= IDLE;
         endcase
         // a flush landing on the final beat needs no flag: the line is simply never validated
         if (flush_i && state == REFILL && !last) discard <= 1'b1;
         if (state == IDLE && !hit_o && !flush_i) valid[pc_idx] <= 1'b0;
         if (last && !discard && !flush_i) valid[fill_idx] <= 1'b1;
         if (flush_i) valid <= '0;
      end
   end
endmodule

// File: tb/tb_instr_cache.sv
// tb_instr_cache: directed checks of lookup, refill, backpressure, flush and reset
module tb_instr_cache;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [31:0] PC_addr_i = '0;
   logic [31:0] instr_o;
   logic        hit_o;
   logic        flush_i = 1'b0;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ready_i = 1'b0;
   logic        mem_valid_i = 1'b0;
   logic [31:0] mem_data_i = '0;
   int          total = 0;
   int          bad = 0;
   instr_cache dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .PC_addr_i   (PC_addr_i),
      .instr_o     (instr_o),
      .hit_o       (hit_o),
      .flush_i     (flush_i),
      .mem_req_o   (mem_req_o),
      .mem_addr_o  (mem_addr_o),
      .mem_ready_i (mem_ready_i),
      .mem_valid_i (mem_valid_i),
      .mem_data_i  (mem_data_i)
   );
   always #5 clk_i = ~clk_i;
   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask
   task automatic expect_hit(input logic [31:0] pc, input logic [31:0] exp);
      PC_addr_i = pc;
      #1;
      check("hit", 32'(hit_o), 32'd1);
      check("instr", instr_o, exp);
   endtask
   task automatic expect_miss(input logic [31:0] pc);
      PC_addr_i = pc;
      #1;
      check("miss", 32'(hit_o), 32'd0);
      check("miss_instr", instr_o, 32'd0);
   endtask
   task automatic wait_req(input logic [31:0] addr);
      int n = 0;
      while (!mem_req_o && n < 20) begin
         tick;
         n++;
      end
      check("req", 32'(mem_req_o), 32'd1);
      check("req_addr", mem_addr_o, addr);
   endtask
   task automatic grant(input logic [31:0] addr, input int stall);
      for (int i = 0; i < stall; i++) begin
         mem_valid_i = 1'b1;
         mem_data_i  = 32'hdeadbeef;
         tick;
         check("bp_req", 32'(mem_req_o), 32'd1);
         check("bp_addr", mem_addr_o, addr);
      end
      mem_valid_i = 1'b0;
      mem_ready_i = 1'b1;
      tick;
      mem_ready_i = 1'b0;
      check("req_drop", 32'(mem_req_o), 32'd0);
   endtask
   task automatic beats(input logic [31:0] k, input int flush_at);
      for (int i = 0; i < 4; i++) begin
         mem_valid_i = 1'b1;
         mem_data_i  = k * 32'(i + 1);
         flush_i     = i == flush_at;
         tick;
      end
      mem_valid_i = 1'b0;
      flush_i     = 1'b0;
   endtask
   task automatic fill(input logic [31:0] addr, input logic [31:0] k, input int stall);
      wait_req(addr);
      grant(addr, stall);
      beats(k, -1);
   endtask
   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
   initial begin
      tick;
      tick;
      check("rst_req", 32'(mem_req_o), 32'd0);
      check("rst_addr", mem_addr_o, 32'd0);
      check("rst_hit", 32'(hit_o), 32'd0);
      check("rst_instr", instr_o, 32'd0);
      rst_i = 1'b0;
      expect_miss(32'h0);
      fill(32'h0, 32'h11, 0);
      expect_hit(32'h0, 32'h11);
      expect_hit(32'h8, 32'h33);
      expect_hit(32'hC, 32'h44);
      expect_miss(32'h40);
      fill(32'h40, 32'h100, 0);
      expect_hit(32'h44, 32'h200);
      expect_hit(32'h0, 32'h11);
      expect_miss(32'h100);
      fill(32'h100, 32'h5000, 0);
      expect_hit(32'h104, 32'hA000);
      expect_miss(32'h0);
      fill(32'h0, 32'h21, 5);
      expect_hit(32'h0, 32'h21);
      expect_hit(32'h4, 32'h42);
      PC_addr_i = 32'h100;
      flush_i   = 1'b1;
      #1;
      check("idle_flush_miss", 32'(hit_o), 32'd0);
      tick;
      flush_i = 1'b0;
      check("idle_flush_noreq", 32'(mem_req_o), 32'd0);
      expect_miss(32'h0);
      expect_miss(32'h40);
      fill(32'h40, 32'h300, 0);
      expect_miss(32'h0);
      wait_req(32'h0);
      grant(32'h0, 0);
      PC_addr_i = 32'h40;
      for (int i = 0; i < 4; i++) begin
         mem_valid_i = 1'b1;
         mem_data_i  = 32'h31 * 32'(i + 1);
         #1;
         check("hum_hit", 32'(hit_o), 32'd1);
         check("hum_instr", instr_o, 32'h300);
         check("hum_addr", mem_addr_o, 32'h0);
         tick;
      end
      mem_valid_i = 1'b0;
      expect_hit(32'h0, 32'h31);
      expect_hit(32'hC, 32'hC4);
      expect_hit(32'h40, 32'h300);
      expect_miss(32'h100);
      wait_req(32'h100);
      grant(32'h100, 0);
      beats(32'h51, 2);
      expect_miss(32'h40);
      expect_miss(32'h100);
      wait_req(32'h100);
      grant(32'h100, 0);
      beats(32'h61, 3);
      expect_miss(32'h100);
      expect_miss(32'h40);
      fill(32'h40, 32'h700, 0);
      expect_hit(32'h48, 32'h1500);
      PC_addr_i = 32'h100;
      wait_req(32'h100);
      grant(32'h100, 0);
      for (int i = 0; i < 2; i++) begin
         mem_valid_i = 1'b1;
         mem_data_i  = 32'h71 * 32'(i + 1);
         tick;
      end
      mem_valid_i = 1'b0;
      expect_hit(32'h40, 32'h700);
      rst_i = 1'b1;
      #1;
      check("mid_rst_hit", 32'(hit_o), 32'd0);
      check("mid_rst_req", 32'(mem_req_o), 32'd0);
      check("mid_rst_addr", mem_addr_o, 32'd0);
      tick;
      rst_i = 1'b0;
      expect_miss(32'h0);
      fill(32'h0, 32'h81, 0);
      expect_hit(32'h0, 32'h81);
      expect_hit(32'hC, 32'h204);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
